// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy,
   output logic             done
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic [CW-1:0]    cnt;
   logic             br;

   // Full-subtractor cell acting on the current LSB of each operand register.
   logic a_i, b_i, d_i, br_next, last, load;

   assign a_i     = a_sr[0];
   assign b_i     = b_sr[0];
   assign d_i     = a_i ^ b_i ^ br;
   assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
   assign last    = (cnt == CW'(WIDTH - 1));
   // A new request is only accepted when no operation is in flight.
   assign load    = start && (state != RUN);

   // NOTE: all state is updated with non-blocking assignments so every flop
   // samples the pre-edge values; reset here is synchronous, as rst is only
   // meaningful on the rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         if (load) begin
            a_sr  <= inA;
            b_sr  <= inB;
            r_sr  <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  busy <= 1'b0;
                  done <= 1'b0;
               end
               RUN: begin
                  a_sr <= a_sr >> 1;
                  b_sr <= b_sr >> 1;
                  r_sr <= {d_i, r_sr[WIDTH-1:1]};
                  br   <= br_next;
                  cnt  <= cnt + CW'(1);
                  if (last) begin
                     // The final difference bit lands in the MSB on this same edge.
                     diff   <= {d_i, r_sr[WIDTH-1:1]};
                     borrow <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                     ovf    <= (a_i ^ b_i) & (d_i ^ a_i);
`endif
                     state  <= DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): table vectors, handshake corner
// cases, exhaustive back-to-back sweep and random operations against an arithmetic model.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] inA;
   logic [W-1:0] inB;
   logic [W-1:0] diff;
   logic         borrow;
   logic         busy;
   logic         done;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .inA    (inA),
      .inB    (inB),
      .diff   (diff),
      .borrow (borrow),
      .busy   (busy),
      .done   (done)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Values the result registers should be holding between completions.
   logic [W-1:0] last_diff   = '0;
   logic         last_borrow = 1'b0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_diff(input int a, input int b);
      return (a - b + (1 << W)) % (1 << W);
   endfunction

   function automatic logic model_borrow(input int a, input int b);
      return a < b;
   endfunction

`ifdef SERIAL_SUB_OVF_EN
   function automatic logic model_ovf(input int a, input int b);
      int sa, sb, r;
      sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
      sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
      r  = sa - sb;
      return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
   endfunction
`endif

   // Issues one request from IDLE or DONE; returns during the DONE cycle (cycle W+1).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic eb, input string tag);
      inA = a; inB = b; start = 1'b1;
      tick();
      start = 1'b0;
      inA = ~a; inB = ~b;
      for (int c = 1; c <= W; c++) begin
         check({tag, " busy"},      busy,   1);
         check({tag, " done_early"}, done,  0);
         check({tag, " diff_hold"}, diff,   last_diff);
         check({tag, " brw_hold"},  borrow, last_borrow);
         tick();
      end
      check({tag, " done"},   done,   1);
      check({tag, " busy_d"}, busy,   0);
      check({tag, " diff"},   diff,   ed);
      check({tag, " borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, " ovf"}, ovf, model_ovf(a, b));
`endif
      last_diff   = ed;
      last_borrow = eb;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " busy"},   busy,   0);
      check({tag, " done"},   done,   0);
      check({tag, " diff"},   diff,   last_diff);
      check({tag, " borrow"}, borrow, last_borrow);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{4'd9,  4'd3,  4'd6,  1'b0, 1'b1};
      tbl[1] = '{4'd3,  4'd9,  4'd10, 1'b1, 1'b1};
      tbl[2] = '{4'd0,  4'd1,  4'd15, 1'b1, 1'b0};
      tbl[3] = '{4'd15, 4'd15, 4'd0,  1'b0, 1'b0};
      tbl[4] = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b1};
      tbl[5] = '{4'd7,  4'd15, 4'd8,  1'b1, 1'b1};
      tbl[6] = '{4'd5,  4'd3,  4'd2,  1'b0, 1'b0};

      // Reset for two cycles with start asserted: reset must win.
      rst = 1'b1; start = 1'b1; inA = 4'd5; inB = 4'd2;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_idle("reset");
`ifdef SERIAL_SUB_OVF_EN
         check("reset ovf", ovf, 0);
`endif
      end
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("idle");
      end

      // Table vectors; each starts from IDLE after a one-cycle gap.
      foreach (tbl[i]) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].ed, tbl[i].eb, $sformatf("tbl%0d", i));
`ifdef SERIAL_SUB_OVF_EN
         check($sformatf("tbl%0d ovf_tbl", i), ovf, tbl[i].eo);
`endif
         tick();
         check_idle($sformatf("tbl%0d after", i));
      end

      // Start pulses in cycles 2 and 3 are ignored; only cycle-0 operands count.
      inA = 4'd9; inB = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      inA = 4'd1; inB = 4'd2; start = 1'b1;
      tick();
      inA = 4'd2; inB = 4'd7;
      tick();
      start = 1'b0;
      check("ign c4 done", done, 0);
      check("ign c4 busy", busy, 1);
      tick();
      check("ign c5 done", done, 1);
      check("ign diff",    diff, 6);
      check("ign borrow",  borrow, 0);
      tick();
      check("ign c6 done", done, 0);
      check("ign c6 busy", busy, 0);
      last_diff = 4'd6; last_borrow = 1'b0;

      // Back-to-back: second request issued in the DONE cycle completes 5 cycles later.
      run_op(4'd12, 4'd4, 4'd8, 1'b0, "b2b0");
      run_op(4'd2,  4'd6, 4'd12, 1'b1, "b2b1");
      tick();
      check_idle("b2b after");

      // Reset asserted in cycle 3 of an operation aborts it without a done pulse.
      inA = 4'd12; inB = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_diff = '0; last_borrow = 1'b0;
      check_idle("abort");
      for (int i = 0; i < 6; i++) begin
         tick();
         check_idle("abort wait");
      end
      run_op(4'd11, 4'd4, 4'd7, 1'b0, "post_abort");

      // Exhaustive sweep, every operation back-to-back with the previous.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_op(W'(a), W'(b), W'(model_diff(a, b)), model_borrow(a, b), "sweep");
      tick();
      check_idle("sweep after");

      // Random operands with random idle gaps.
      for (int n = 0; n < 40; n++) begin
         int a, b, gap;
         a   = int'($urandom_range(15, 0));
         b   = int'($urandom_range(15, 0));
         gap = int'($urandom_range(3, 0));
         for (int g = 0; g < gap; g++) tick();
         run_op(W'(a), W'(b), W'(model_diff(a, b)), model_borrow(a, b), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
